// File: rtl/fifo_reader_pkg.sv
// fifo_reader_pkg: shared types and constants for the FIFO read-side controller.
//   state_e          : FSM state encoding (IDLE..CAP, 3 bits)
//   FIFO_STROBE_LAT  : edges from read_o sampled low until FIFO dout updates
//   HOLD_W           : width of the strobe hold counter (HOLD up to 15)
package fifo_reader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_WAIT = 3'd3,
    ST_CAP  = 3'd4
  } state_e;

  localparam int FIFO_STROBE_LAT = 3;
  localparam int HOLD_W          = 4;

endpackage

// File: rtl/fifo_reader_strobe_gen.sv
// strobe_gen: owns the registered FIFO read strobe and its hold counter.
//   clk, rst (async, active-low)
//   start  : begin a strobe; read_o rises on this edge
//   read_o : registered strobe to the FIFO read pin
//   done   : read_o is high and the hold count is exhausted; read_o falls next edge
module strobe_gen
  import fifo_reader_pkg::*;
#(
  parameter int HOLD = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  output logic read_o,
  output logic done
);

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD - 1);

  logic              read_q, read_d;
  logic [HOLD_W-1:0] cnt_q, cnt_d;

  always_comb begin
    read_d = read_q;
    cnt_d  = cnt_q;
    if (start) begin
      read_d = 1'b1;
      cnt_d  = HOLD_LOAD;
    end else if (read_q) begin
      if (cnt_q == '0) read_d = 1'b0;
      else             cnt_d  = cnt_q - HOLD_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      read_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      read_q <= read_d;
      cnt_q  <= cnt_d;
    end
  end

  assign read_o = read_q;
  assign done   = read_q && (cnt_q == '0);

endmodule

// File: rtl/fifo_reader.sv
// fifo_reader: read-side controller for the team FIFO. Strobes the FIFO read
// pin (popped on its falling edge), waits out the FIFO pipeline, captures dout
// and offers it downstream on a valid/ready stream.
//   clk, rst (async, active-low)
//   en         : allow new strobes; an in-flight strobe always completes
//   fifo_empty : FIFO empty flag (sampled in IDLE only)
//   fifo_dout  : FIFO registered data out
//   read_o     : FIFO read strobe (registered)
//   m_data/m_valid/m_ready : output stream. A word transfers on every rising
//                edge where m_valid & m_ready; m_data is held while m_valid & ~m_ready.
//   busy       : FSM not in IDLE
//   rd_count   : words popped, wraps modulo 2^CBIT
//   dbg_state  : current FSM state
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int DBIT = 3,
  parameter int HOLD = 1,
  parameter int CBIT = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            fifo_empty,
  input  logic [DBIT-1:0] fifo_dout,
  output logic            read_o,
  output logic [DBIT-1:0] m_data,
  output logic            m_valid,
  input  logic            m_ready,
  output logic            busy,
  output logic [CBIT-1:0] rd_count,
  output state_e          dbg_state
);

  state_e            state_q, state_d;
  logic [DBIT-1:0]   m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic [CBIT-1:0]   rd_count_q, rd_count_d;
  logic              start;
  logic              done;

  strobe_gen #(.HOLD(HOLD)) u_strobe (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .read_o (read_o),
    .done   (done)
  );

  // Issue only when the output slot is free or being drained this edge, so
  // an unconsumed word can never be overwritten by the next capture.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && !fifo_empty && (!m_valid_q || m_ready)) begin
          start   = 1'b1;
          state_d = ST_HI;
        end
      end
      ST_HI:   if (done) state_d = ST_LO;
      ST_LO:   state_d = ST_WAIT;
      ST_WAIT: state_d = ST_CAP;
      ST_CAP:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Capture in CAP takes priority over the consume-clear.
  always_comb begin
    m_data_d   = m_data_q;
    m_valid_d  = m_valid_q;
    rd_count_d = rd_count_q;
    if (m_valid_q && m_ready) m_valid_d = 1'b0;
    if (state_q == ST_CAP) begin
      m_data_d   = fifo_dout;
      m_valid_d  = 1'b1;
      rd_count_d = rd_count_q + CBIT'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      m_data_q   <= '0;
      m_valid_q  <= 1'b0;
      rd_count_q <= '0;
    end else begin
      state_q    <= state_d;
      m_data_q   <= m_data_d;
      m_valid_q  <= m_valid_d;
      rd_count_q <= rd_count_d;
    end
  end

  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign rd_count  = rd_count_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule
